// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_controller_pkg : shared encodings for the multicycle ARM control unit
// Revision 1.0
// ============================================================================
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [1:0] alu;
        logic       no_write;
        logic       known;
        logic       force_flags;
        logic       arith;
    } dp_decode_t;

    // Unrecognised commands fall back to ADD and never touch the flags.
    function automatic dp_decode_t decode_cmd(input logic [3:0] cmd);
        dp_decode_t d;
        d = '{alu: ALU_ADD, no_write: 1'b0, known: 1'b1, force_flags: 1'b0, arith: 1'b0};
        case (cmd)
            CMD_ADD: d.arith = 1'b1;
            CMD_SUB: begin d.alu = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.alu = ALU_AND;
            CMD_ORR: d.alu = ALU_ORR;
            CMD_CMP: begin
                d.alu         = ALU_SUB;
                d.arith       = 1'b1;
                d.no_write    = 1'b1;
                d.force_flags = 1'b1;
            end
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_cond_check.sv
`default_nettype none
// ============================================================================
// multicycle_controller_cond_check : ARM condition-field evaluation against NZCV
// Revision 1.0
// ============================================================================
module multicycle_controller_cond_check
    import multicycle_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : main FSM, NZCV register and datapath control decode
// Revision 1.0
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    state_t     state;
    logic [3:0] flags;
    logic       cond_ok;
    logic       cond_ex;
    dp_decode_t dp;
    logic       nz_en;
    logic       cv_en;
    logic       pc_write, mem_write, reg_write, ir_write;

    multicycle_controller_cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign dp    = decode_cmd(Funct[4:1]);
    assign nz_en = cond_ok & dp.known & (Funct[0] | dp.force_flags);
    assign cv_en = nz_en & dp.arith;

    // Condition is captured in DECODE so a flag update in EXEC cannot gate
    // the same instruction's write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            flags   <= 4'b0000;
            cond_ok <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    cond_ok <= cond_ex;
                    case (Op)
                        OP_MEM:  state <= MEMADR;
                        OP_DP:   state <= Funct[5] ? EXECI : EXECR;
                        OP_BR:   state <= BRANCH;
                        default: state <= UNKNOWN;
                    endcase
                end
                MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR, EXECI: begin
                    state <= ALUWB;
                    if (nz_en) flags[3:2] <= ALUFlags[3:2];
                    if (cv_en) flags[1:0] <= ALUFlags[1:0];
                end
                MEMWB, MEMWR, ALUWB, BRANCH: state <= FETCH;
                default: state <= UNKNOWN;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        ir_write   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: ALUSrcB = SRCB_EXTIMM;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = cond_ok;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = cond_ok;
            end
            EXECR: ALUControl = dp.alu;
            EXECI: begin
                ALUSrcB    = SRCB_EXTIMM;
                ALUControl = dp.alu;
            end
            ALUWB: begin
                if (Rd == 4'd15) pc_write  = cond_ok & ~dp.no_write;
                else             reg_write = cond_ok & ~dp.no_write;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                pc_write  = cond_ok;
            end
            default: ;
        endcase
    end

    // Enables are forced low for as long as reset is held, including the
    // FETCH state the register drops into on assertion.
    assign PCWrite  = pc_write  & reset;
    assign MemWrite = mem_write & reset;
    assign RegWrite = reg_write & reset;
    assign IRWrite  = ir_write  & reset;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : directed + randomized check against a cycle model
// Revision 1.0
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_flags = 4'b0000;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;            1: return !z;
            2: return cy;           3: return !cy;
            4: return n;            5: return !n;
            6: return v;            7: return !v;
            8: return cy && !z;     9: return !cy || z;
            10: return n == v;      11: return n != v;
            12: return !z && n == v; 13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Expected control word for cycle k of an instruction (k=0 is fetch).
    function automatic logic [15:0] expect_word(input logic [1:0] op, input logic [5:0] fn,
                                                input logic [3:0] rd, input int k, input logic pass);
        logic pcw, mw, rw, irw, adr, srca, wr;
        logic [1:0] res, srcb, ctl, rsrc;
        logic [3:0] cmd;
        {pcw, mw, rw, irw, adr, srca} = '0;
        res = 2'b00; srcb = 2'b00; ctl = 2'b00;
        cmd  = fn[4:1];
        rsrc = {op == 2'b01 && !fn[0], op == 2'b10};
        if (k == 0) begin
            irw = 1; pcw = 1; srca = 1; srcb = 2'b10; res = 2'b10;
        end else if (k == 1) begin
            srca = 1; srcb = 2'b10; res = 2'b10;
        end else if (op == 2'b10) begin
            srcb = 2'b01; res = 2'b10; pcw = pass;
        end else if (op == 2'b01) begin
            if (k == 2) srcb = 2'b01;
            else if (k == 3) begin adr = 1; if (!fn[0]) mw = pass; end
            else begin res = 2'b01; rw = pass; end
        end else if (op == 2'b00) begin
            if (k == 2) begin
                srcb = fn[5] ? 2'b01 : 2'b00;
                ctl  = alu_of(cmd);
            end else begin
                wr = pass && cmd != 4'b1010;
                if (rd == 4'd15) pcw = wr; else rw = wr;
            end
        end
        return {pcw, mw, rw, irw, adr, res, srca, srcb, op, rsrc, ctl};
    endfunction

    // Runs one instruction from fetch; abort_k >= 0 asserts reset in that cycle.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] af, input int abort_k);
        int n;
        logic pass;
        logic [3:0] cmd;
        cmd  = fn[4:1];
        pass = cond_pass(c, m_flags);
        case (op)
            2'b00: n = 4;
            2'b01: n = fn[0] ? 5 : 4;
            2'b10: n = 3;
            default: n = 12;
        endcase
        Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("ctrl", obs, expect_word(op, fn, rd, k, pass));
            if (k == abort_k) begin
                #2 reset = 1'b0;
                #1 check("rst_mid_en", {12'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 16'd0);
                m_flags = 4'b0000;
                @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
            if (op == 2'b00 && k == 2 && pass &&
                (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}) &&
                (fn[0] || cmd == 4'b1010)) begin
                m_flags[3:2] = af[3:2];
                if (cmd inside {4'b0100, 4'b0010, 4'b1010}) m_flags[1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0] op;
        logic [3:0] c, rd;
        logic [5:0] fn;
        logic [3:0] cmds [5];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", {12'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 16'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr(4'hE, 2'b00, 6'b101000, 4'd3, 4'b0000, -1);   // ADD imm
        run_instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000, -1);   // LDR
        run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100, -1);   // SUBS -> Z
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);   // BEQ taken
        run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);   // BNE not taken
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1000, -1);   // CMP -> N
        run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);   // BMI taken
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);   // BEQ not taken
        run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, -1);  // ADD to PC
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, -1);   // CMP -> Z
        run_instr(4'hE, 2'b01, 6'b011000, 4'd5, 4'b0000, 3);    // STR, reset in MEMWR
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);   // BEQ: flags cleared
        run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);   // BNE taken
        run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 11);   // UNKNOWN, then reset

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 2));
            c  = 4'($urandom_range(0, 15));
            fn = 6'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom);
            if (op == 2'b00 && $urandom_range(0, 3) != 0)
                fn[4:1] = cmds[$urandom_range(0, 4)];
            run_instr(c, op, fn, rd, 4'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
